// File: rtl/sprite_rom_arbiter_if.sv
// Client/ROM-side bundle for sprite_rom_arbiter: request/grant, ROM strobe/data and return path.
// master = draw clients plus ROM model, slave = the arbiter.
interface sprite_rom_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8
);
    logic                      en;
    logic [N_REQ-1:0]          req;
    logic [N_REQ*ADDR_W-1:0]   req_addr;
    logic [N_REQ-1:0]          gnt;
    logic                      rom_rd;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_W-1:0]         rom_data;
    logic [N_REQ-1:0]          rd_valid;
    logic [DATA_W-1:0]         rd_data;
    logic                      busy;

    modport master (
        output en, req, req_addr, rom_data,
        input  gnt, rom_rd, rom_addr, rd_valid, rd_data, busy
    );

    modport slave (
        input  en, req, req_addr, rom_data,
        output gnt, rom_rd, rom_addr, rd_valid, rd_data, busy
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite/palette ROM among N_REQ draw clients;
// an owner shift register routes each read's data back to the client that was granted.
module sprite_rom_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ROM_LAT = 2
) (
    input logic                 Clk,
    input logic                 Reset,
    sprite_rom_arbiter_if.slave bus
);
    localparam int unsigned PtrW = $clog2(N_REQ);

    logic [ADDR_W-1:0] addr_arr [N_REQ];
    logic [N_REQ-1:0]  eligible;
    logic [N_REQ-1:0]  gnt_d, gnt_q;
    logic [PtrW-1:0]   ptr_d, ptr_q;
    logic [PtrW-1:0]   idx_w;
    logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
    logic [N_REQ-1:0]  own_q [ROM_LAT];
    logic              own_any;
    logic [N_REQ-1:0]  rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              found;

    for (genvar g = 0; g < N_REQ; g++) begin : g_addr
        assign addr_arr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
    end

    // A client is masked in its own grant cycle so a held req is never granted twice.
    always_comb begin
        eligible   = bus.req & ~gnt_q;
        gnt_d      = '0;
        ptr_d      = ptr_q;
        rom_addr_d = rom_addr_q;
        found      = 1'b0;
        idx_w      = '0;
        if (bus.en) begin
            for (int i = 0; i < N_REQ; i++) begin
                idx_w = PtrW'((32'(ptr_q) + 32'(i)) % N_REQ);
                if (!found && eligible[idx_w]) begin
                    found        = 1'b1;
                    gnt_d[idx_w] = 1'b1;
                    rom_addr_d   = addr_arr[idx_w];
                    ptr_d        = PtrW'((32'(idx_w) + 32'd1) % N_REQ);
                end
            end
        end
    end

    always_comb begin
        own_any = 1'b0;
        for (int j = 0; j < ROM_LAT; j++) begin
            own_any = own_any | (|own_q[j]);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            gnt_q      <= '0;
            ptr_q      <= '0;
            rom_addr_q <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            for (int j = 0; j < ROM_LAT; j++) begin
                own_q[j] <= '0;
            end
        end else begin
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            rom_addr_q <= rom_addr_d;
            own_q[0]   <= gnt_q;
            for (int j = 1; j < ROM_LAT; j++) begin
                own_q[j] <= own_q[j-1];
            end
            // Last owner stage lines up with the cycle rom_data is valid.
            rd_valid_q <= own_q[ROM_LAT-1];
            if (|own_q[ROM_LAT-1]) begin
                rd_data_q <= bus.rom_data;
            end
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.rom_rd   = |gnt_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.busy     = (|gnt_q) | own_any | (|rd_valid_q);
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model (round-robin pick, list of outstanding reads with due times).
module tb_sprite_rom_arbiter;
    localparam int N   = 4;
    localparam int AW  = 12;
    localparam int DW  = 8;
    localparam int LAT = 2;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    sprite_rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sprite_rom_arbiter #(
        .N_REQ  (N),
        .ADDR_W (AW),
        .DATA_W (DW),
        .ROM_LAT(LAT)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    // Synchronous ROM, data valid two cycles after the address is presented.
    logic [AW-1:0] rom_a1 = '0;
    always @(posedge Clk) begin
        rom_a1       <= bus.rom_addr;
        bus.rom_data <= rom_f(rom_a1);
    end

    typedef struct {
        int            client;
        logic [AW-1:0] addr;
        int            gcyc;
    } rd_t;

    rd_t           q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            m_gnt   = -1;
    int            m_ptr   = 0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_rd_data = '0;
    int            cnt_g, cnt_v;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Compute expectations for the next cycle from the inputs applied in this one.
    task automatic model_update();
        int k;
        int i;
        k = -1;
        if (Reset) begin
            m_gnt     = -1;
            m_ptr     = 0;
            m_addr    = '0;
            m_rd_data = '0;
            q.delete();
        end else begin
            if (bus.en) begin
                for (int j = 0; j < N; j++) begin
                    i = (m_ptr + j) % N;
                    if (k < 0 && ((bus.req >> i) & 1) != 0 && m_gnt != i) k = i;
                end
            end
            m_gnt = k;
            if (k >= 0) begin
                m_addr = AW'(bus.req_addr >> (k * AW));
                m_ptr  = (k + 1) % N;
                q.push_back('{client: k, addr: m_addr, gcyc: cyc + 1});
            end
            foreach (q[e]) begin
                if (q[e].gcyc + LAT + 1 == cyc + 1) m_rd_data = rom_f(q[e].addr);
            end
            while (q.size() > 0 && q[0].gcyc + LAT + 1 < cyc + 1) void'(q.pop_front());
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg;
        logic [N-1:0] ev;
        logic         eb;
        eg = '0;
        ev = '0;
        eb = 1'b0;
        if (m_gnt >= 0) eg = N'(1) << m_gnt;
        foreach (q[e]) begin
            if (q[e].gcyc + LAT + 1 == cyc) ev = ev | (N'(1) << q[e].client);
            if (q[e].gcyc <= cyc && cyc <= q[e].gcyc + LAT + 1) eb = 1'b1;
        end
        check_eq("gnt", bus.gnt, eg);
        check_eq("rom_rd", bus.rom_rd, |eg);
        check_eq("rom_addr", bus.rom_addr, m_addr);
        check_eq("rd_valid", bus.rd_valid, ev);
        check_eq("rd_data", bus.rd_data, m_rd_data);
        check_eq("busy", bus.busy, eb);
    endtask

    task automatic step();
        model_update();
        @(posedge Clk);
        cyc++;
        @(negedge Clk);
        check_outputs();
    endtask

    task automatic set_client(input int i, input logic r, input logic [AW-1:0] a);
        bus.req[i]                = r;
        bus.req_addr[i*AW +: AW]  = a;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    task automatic drive_random();
        Reset  = ($urandom_range(0, 199) == 0);
        bus.en = ($urandom_range(0, 9) != 0);
        for (int i = 0; i < N; i++) begin
            if (m_gnt == i)
                set_client(i, $urandom_range(0, 3) != 0, AW'($urandom));
            else if (!bus.req[i] && $urandom_range(0, 3) == 0)
                set_client(i, 1'b1, AW'($urandom));
        end
    endtask

    initial begin
        bus.en       = 1'b1;
        bus.req      = '0;
        bus.req_addr = '0;
        step();
        do_reset();
        check_eq("rst_gnt", bus.gnt, 0);
        check_eq("rst_busy", bus.busy, 0);

        // 1: single read from client 0
        set_client(0, 1'b1, 12'h010);
        step();
        check_eq("t1_gnt", bus.gnt, 4'b0001);
        bus.req = '0;
        step();
        check_eq("t1_busy1", bus.busy, 1);
        step();
        check_eq("t1_busy2", bus.busy, 1);
        step();
        check_eq("t1_rdv", bus.rd_valid, 4'b0001);
        check_eq("t1_data", bus.rd_data, 8'hB5);
        step();
        check_eq("t1_rdv_off", bus.rd_valid, 0);

        // 2: all clients requesting continuously
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.req = (i < 5) ? 4'b1111 : 4'b0000;
            step();
            if (i < 5) check_eq("t2_gnt", bus.gnt, 32'(1) << (i % 4));
            if (i >= 3) check_eq("t2_rdv", bus.rd_valid, 32'(1) << ((i - 3) % 4));
        end

        // 3: wrap-around from ptr=2
        do_reset();
        bus.req = 4'b0010;
        step();
        check_eq("t3_gnt1", bus.gnt, 4'b0010);
        bus.req = 4'b0011;
        step();
        check_eq("t3_gnt0", bus.gnt, 4'b0001);
        bus.req = 4'b0010;
        step();
        check_eq("t3_gnt1b", bus.gnt, 4'b0010);
        bus.req = '0;
        repeat (4) step();

        // 4: en dropped while a read is in flight
        set_client(2, 1'b1, 12'h3C7);
        step();
        check_eq("t4_gnt2", bus.gnt, 4'b0100);
        bus.en = 1'b0;
        bus.req = '0;
        set_client(3, 1'b1, 12'h155);
        for (int i = 1; i <= 5; i++) begin
            step();
            check_eq("t4_nognt", bus.gnt, 0);
            if (i == 3) begin
                check_eq("t4_rdv", bus.rd_valid, 4'b0100);
                check_eq("t4_data", bus.rd_data, 8'h62);
            end
        end
        bus.en = 1'b1;
        step();
        check_eq("t4_gnt3", bus.gnt, 4'b1000);
        bus.req = '0;
        repeat (4) step();

        // 5: reset one cycle after a grant discards the read
        set_client(2, 1'b1, 12'h0F0);
        step();
        check_eq("t5_gnt2", bus.gnt, 4'b0100);
        bus.req = '0;
        step();
        do_reset();
        check_eq("t5_gnt", bus.gnt, 0);
        check_eq("t5_rom_rd", bus.rom_rd, 0);
        check_eq("t5_rom_addr", bus.rom_addr, 0);
        check_eq("t5_rdv", bus.rd_valid, 0);
        check_eq("t5_data", bus.rd_data, 0);
        check_eq("t5_busy", bus.busy, 0);
        repeat (4) begin
            step();
            check_eq("t5_no_rdv", bus.rd_valid, 0);
        end
        bus.req = 4'b1111;
        step();
        check_eq("t5_first", bus.gnt, 4'b0001);
        bus.req = '0;
        repeat (4) step();

        // 6: req held across the grant cycle only
        cnt_g = 0;
        cnt_v = 0;
        set_client(1, 1'b1, 12'h777);
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 1) bus.req = '0;
            cnt_g += int'(bus.gnt[1]);
            cnt_v += int'(bus.rd_valid[1]);
        end
        check_eq("t6_gnt_cnt", cnt_g, 1);
        check_eq("t6_rdv_cnt", cnt_v, 1);

        // Random traffic
        repeat (3000) begin
            drive_random();
            step();
        end
        Reset   = 1'b0;
        bus.en  = 1'b1;
        bus.req = '0;
        repeat (6) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
